// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: merges the cpu instruction port (I*) and data port (D*)
// onto a single memory port (M*). Round-robin arbitration between the two
// masters, with the data side winning the first tie after reset. The grant is
// registered, so a request in IDLE produces MREQ one cycle later, and every
// transfer is followed by one dead IDLE cycle.
//
// Handshake: a master raises xREQ with stable request fields and holds them
// until its transfer ends. Each cycle with MACK=1 while the master owns the bus
// is one accepted beat, reported back as xACK. xSTALL mirrors MSTALL for the
// owner and is forced to 1 for a master that does not own the bus. Dropping
// xREQ before the last beat aborts the transfer.
module cpu_mem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  // instruction port
  input  logic [AW-1:0]     IADDR,
  input  logic [1:0]        IBURST,
  input  logic              IREQ,
  input  logic              IWRB,
  input  logic [DW-1:0]     IWDATA,
  input  logic [DW/8-1:0]   IBSTROBE,
  output logic [DW-1:0]     IRDATA,
  output logic              IACK,
  output logic              ISTALL,
  // data port
  input  logic [AW-1:0]     DADDR,
  input  logic [1:0]        DBURST,
  input  logic              DREQ,
  input  logic              DWRB,
  input  logic [DW-1:0]     DWDATA,
  input  logic [DW/8-1:0]   DBSTROBE,
  output logic [DW-1:0]     DRDATA,
  output logic              DACK,
  output logic              DSTALL,
  // memory port
  output logic [AW-1:0]     MADDR,
  output logic [1:0]        MBURST,
  output logic              MREQ,
  output logic              MWRB,
  output logic [DW-1:0]     MWDATA,
  output logic [DW/8-1:0]   MBSTROBE,
  input  logic [DW-1:0]     MRDATA,
  input  logic              MACK,
  input  logic              MSTALL,
  // debug: current owner (00 idle, 01 I, 10 D)
  output logic [1:0]        grant_o
);

  localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST_LEN - 1);

  // State encoding doubles as the debug grant value.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_I = 2'b01,
    GNT_D = 2'b10
  } state_t;

  state_t          state, state_nxt;
  logic            last_grant, last_grant_nxt;  // 0 = I served last, 1 = D
  logic [CW-1:0]   beat_cnt, beat_cnt_nxt;
  logic            is_burst;
  logic            xfer_last;

  // Read data is broadcast; each port qualifies it with its own ACK.
  assign IRDATA  = MRDATA;
  assign DRDATA  = MRDATA;
  assign grant_o = state;

  // MBURST is zero in IDLE, so this is only meaningful while granted.
  // Reserved burst type 11 behaves as a single beat.
  assign is_burst  = (MBURST == 2'b01) || (MBURST == 2'b10);
  assign xfer_last = !is_burst || (beat_cnt == CNT_LAST);

  // State, round-robin history and beat counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b0;
      beat_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      beat_cnt   <= beat_cnt_nxt;
    end
  end

  // Next-state: arbitrate in IDLE, count beats and detect completion/abort
  // while a master owns the bus.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    beat_cnt_nxt   = beat_cnt;
    case (state)
      IDLE: begin
        if (IREQ && DREQ) begin
          state_nxt = last_grant ? GNT_I : GNT_D;
        end else if (IREQ) begin
          state_nxt = GNT_I;
        end else if (DREQ) begin
          state_nxt = GNT_D;
        end
      end
      GNT_I, GNT_D: begin
        // MREQ is the owner's REQ; a dropped REQ aborts without counting.
        if (!MREQ || (MACK && xfer_last)) begin
          state_nxt      = IDLE;
          beat_cnt_nxt   = '0;
          last_grant_nxt = (state == GNT_D);
        end else if (MACK) begin
          beat_cnt_nxt = beat_cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt    = IDLE;
        beat_cnt_nxt = '0;
      end
    endcase
  end

  // Output mux: copy the owner's request fields onto M*, route MACK/MSTALL
  // back to the owner only.
  always_comb begin
    MADDR    = '0;
    MBURST   = 2'b00;
    MREQ     = 1'b0;
    MWRB     = 1'b0;
    MWDATA   = '0;
    MBSTROBE = '0;
    IACK     = 1'b0;
    DACK     = 1'b0;
    ISTALL   = 1'b1;
    DSTALL   = 1'b1;
    case (state)
      GNT_I: begin
        MADDR    = IADDR;
        MBURST   = IBURST;
        MREQ     = IREQ;
        MWRB     = IWRB;
        MWDATA   = IWDATA;
        MBSTROBE = IBSTROBE;
        IACK     = MACK;
        ISTALL   = MSTALL;
      end
      GNT_D: begin
        MADDR    = DADDR;
        MBURST   = DBURST;
        MREQ     = DREQ;
        MWRB     = DWRB;
        MWDATA   = DWDATA;
        MBSTROBE = DBSTROBE;
        DACK     = MACK;
        DSTALL   = MSTALL;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter: a cycle table for reset, single reads,
// contention and round-robin order, followed by hand-written sequences for
// bursts, abort and reset mid-transfer.
module tb_cpu_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BL = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   IADDR, DADDR, MADDR;
  logic [1:0]      IBURST, DBURST, MBURST;
  logic            IREQ, DREQ, MREQ;
  logic            IWRB, DWRB, MWRB;
  logic [DW-1:0]   IWDATA, DWDATA, MWDATA;
  logic [DW/8-1:0] IBSTROBE, DBSTROBE, MBSTROBE;
  logic [DW-1:0]   IRDATA, DRDATA, MRDATA;
  logic            IACK, DACK, MACK;
  logic            ISTALL, DSTALL, MSTALL;
  logic [1:0]      grant_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];

  cpu_mem_arbiter #(.AW(AW), .DW(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst),
    .IADDR(IADDR), .IBURST(IBURST), .IREQ(IREQ), .IWRB(IWRB),
    .IWDATA(IWDATA), .IBSTROBE(IBSTROBE), .IRDATA(IRDATA), .IACK(IACK),
    .ISTALL(ISTALL),
    .DADDR(DADDR), .DBURST(DBURST), .DREQ(DREQ), .DWRB(DWRB),
    .DWDATA(DWDATA), .DBSTROBE(DBSTROBE), .DRDATA(DRDATA), .DACK(DACK),
    .DSTALL(DSTALL),
    .MADDR(MADDR), .MBURST(MBURST), .MREQ(MREQ), .MWRB(MWRB),
    .MWDATA(MWDATA), .MBSTROBE(MBSTROBE), .MRDATA(MRDATA), .MACK(MACK),
    .MSTALL(MSTALL),
    .grant_o(grant_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  // Inputs change 1ns after the rising edge; outputs are sampled 2ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic        ireq;
    logic        dreq;
    logic        mack;
    logic        mstall;
    logic [31:0] mrdata;
    logic        e_mreq;
    logic        e_iack;
    logic        e_dack;
    logic        e_istall;
    logic        e_dstall;
    logic [1:0]  e_gnt;
    logic [31:0] e_maddr;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic ir, input logic dr,
                              input logic ma, input logic ms, input logic [31:0] rd,
                              input logic mq, input logic ia, input logic da,
                              input logic is, input logic ds, input logic [1:0] g,
                              input logic [31:0] a);
    vec_t v;
    v.rst = r; v.ireq = ir; v.dreq = dr; v.mack = ma; v.mstall = ms; v.mrdata = rd;
    v.e_mreq = mq; v.e_iack = ia; v.e_dack = da; v.e_istall = is; v.e_dstall = ds;
    v.e_gnt = g; v.e_maddr = a;
    return v;
  endfunction

  vec_t vecs[14];

  // ---------------- driver tasks ----------------
  // Serve the current owner: MACK on even cycles, MSTALL on odd cycles, until
  // the grant leaves. Counts acknowledged beats against exp_beats.
  task automatic serve(input logic use_d, input logic [1:0] bt, input int exp_beats);
    int   acks;
    int   cyc;
    bit   done;
    logic [1:0] own;
    acks = 0; cyc = 0; done = 1'b0;
    own  = use_d ? 2'b10 : 2'b01;
    while (!done && cyc < 40) begin
      MACK   = (cyc % 2 == 0);
      MSTALL = (cyc % 2 == 1);
      MRDATA = 32'hC0DE_0000 + 32'(cyc);
      #2;
      if (grant_o !== own) begin
        done = 1'b1;
      end else begin
        chk("burst_type", 32'(MBURST), 32'(bt));
        chk("owner_stall", 32'(use_d ? DSTALL : ISTALL), 32'(MSTALL));
        chk("other_stall", 32'(use_d ? ISTALL : DSTALL), 32'h1);
        chk("other_ack", 32'(use_d ? IACK : DACK), 32'h0);
        if (MACK) exp_q.push_back(MRDATA);
        if ((use_d ? DACK : IACK) === 1'b1) begin
          acks++;
          if (exp_q.size() == 0) chk("beat_unexpected", 32'h1, 32'h0);
          else chk("beat_data", use_d ? DRDATA : IRDATA, exp_q.pop_front());
        end
        step();
        cyc++;
      end
    end
    MACK   = 1'b0;
    MSTALL = 1'b0;
    exp_q.delete();
    chk("beat_count", 32'(acks), 32'(exp_beats));
    chk("end_idle", 32'(grant_o), 32'h0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // ---------------- main test ----------------
  initial begin
    //            rst ir dr ma ms mrdata        mq ia da is ds gnt    maddr
    vecs[0]  = mk(1, 1, 1, 0, 0, 32'h0,         0, 0, 0, 1, 1, 2'b00, 32'h0);
    vecs[1]  = mk(1, 1, 1, 0, 0, 32'h0,         0, 0, 0, 1, 1, 2'b00, 32'h0);
    vecs[2]  = mk(0, 1, 1, 0, 0, 32'h0,         0, 0, 0, 1, 1, 2'b00, 32'h0);
    vecs[3]  = mk(0, 1, 1, 0, 0, 32'h0,         1, 0, 0, 1, 0, 2'b10, 32'h1000);
    vecs[4]  = mk(0, 1, 1, 0, 1, 32'h0,         1, 0, 0, 1, 1, 2'b10, 32'h1000);
    vecs[5]  = mk(0, 1, 1, 1, 0, 32'hDEADBEEF,  1, 0, 1, 1, 0, 2'b10, 32'h1000);
    vecs[6]  = mk(0, 1, 1, 0, 0, 32'h0,         0, 0, 0, 1, 1, 2'b00, 32'h0);
    vecs[7]  = mk(0, 1, 1, 1, 0, 32'h11111111,  1, 1, 0, 0, 1, 2'b01, 32'h208);
    vecs[8]  = mk(0, 1, 1, 1, 0, 32'h0,         0, 0, 0, 1, 1, 2'b00, 32'h0);
    vecs[9]  = mk(0, 1, 1, 1, 0, 32'h22222222,  1, 0, 1, 1, 0, 2'b10, 32'h1000);
    vecs[10] = mk(0, 1, 1, 0, 0, 32'h0,         0, 0, 0, 1, 1, 2'b00, 32'h0);
    vecs[11] = mk(0, 1, 1, 1, 1, 32'h33333333,  1, 1, 0, 1, 1, 2'b01, 32'h208);
    vecs[12] = mk(0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 1, 1, 2'b00, 32'h0);
    vecs[13] = mk(0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 1, 1, 2'b00, 32'h0);

    // reset block
    rst = 1'b1;
    IADDR = 32'h208;  IBURST = 2'b00; IREQ = 1'b1; IWRB = 1'b0;
    IWDATA = 32'h0;   IBSTROBE = 4'hF;
    DADDR = 32'h1000; DBURST = 2'b00; DREQ = 1'b1; DWRB = 1'b0;
    DWDATA = 32'h0;   DBSTROBE = 4'hF;
    MRDATA = 32'h0;   MACK = 1'b0;    MSTALL = 1'b0;
    step();

    // table: reset, single D read, contention and alternation
    for (int i = 0; i < 14; i++) begin
      rst    = vecs[i].rst;
      IREQ   = vecs[i].ireq;
      DREQ   = vecs[i].dreq;
      MACK   = vecs[i].mack;
      MSTALL = vecs[i].mstall;
      MRDATA = vecs[i].mrdata;
      #2;
      chk($sformatf("v%0d_mreq", i),   32'(MREQ),    32'(vecs[i].e_mreq));
      chk($sformatf("v%0d_iack", i),   32'(IACK),    32'(vecs[i].e_iack));
      chk($sformatf("v%0d_dack", i),   32'(DACK),    32'(vecs[i].e_dack));
      chk($sformatf("v%0d_istall", i), 32'(ISTALL),  32'(vecs[i].e_istall));
      chk($sformatf("v%0d_dstall", i), 32'(DSTALL),  32'(vecs[i].e_dstall));
      chk($sformatf("v%0d_grant", i),  32'(grant_o), 32'(vecs[i].e_gnt));
      chk($sformatf("v%0d_maddr", i),  MADDR,        vecs[i].e_maddr);
      chk($sformatf("v%0d_drdata", i), DRDATA,       vecs[i].mrdata);
      chk($sformatf("v%0d_irdata", i), IRDATA,       vecs[i].mrdata);
      step();
    end

    // I WRAP fill, 4 beats with stalls in between
    IREQ = 1'b1; IBURST = 2'b10; IADDR = 32'h208;
    #2;
    chk("wrap_wait_grant", 32'(grant_o), 32'h0);
    step();
    serve(1'b0, 2'b10, BL);
    IREQ = 1'b0; IBURST = 2'b00;
    step();

    // abort: D INCR dropped after 2 beats while I is pending
    DREQ = 1'b1; DBURST = 2'b01; IREQ = 1'b1;
    step();
    for (int k = 0; k < 2; k++) begin
      MACK = 1'b1;
      #2;
      chk("abort_grant_d", 32'(grant_o), 32'h2);
      chk("abort_beat_ack", 32'(DACK), 32'h1);
      step();
    end
    DREQ = 1'b0;
    #2;
    chk("abort_mreq_low", 32'(MREQ), 32'h0);
    chk("abort_ack_fwd", 32'(DACK), 32'h1);
    step();
    MACK = 1'b0;
    #2;
    chk("abort_idle", 32'(grant_o), 32'h0);
    step();
    #0;
    chk("abort_then_i", 32'(grant_o), 32'h1);
    serve(1'b0, 2'b00, 1);
    IREQ = 1'b0;
    // full D INCR after the abort needs all BL beats
    DREQ = 1'b1; DBURST = 2'b01;
    step();
    serve(1'b1, 2'b01, BL);
    DREQ = 1'b0;
    step();

    // write strobes, then reset mid-transfer
    DREQ = 1'b1; DWRB = 1'b1; DBSTROBE = 4'b0101; DWDATA = 32'hA5A5A5A5; DBURST = 2'b01;
    step();
    #2;
    chk("wr_grant", 32'(grant_o), 32'h2);
    chk("wr_mwrb", 32'(MWRB), 32'h1);
    chk("wr_mbstrobe", 32'(MBSTROBE), 32'h5);
    chk("wr_mwdata", MWDATA, 32'hA5A5A5A5);
    chk("wr_mburst", 32'(MBURST), 32'h1);
    MACK = 1'b1;
    step();
    MACK = 1'b0; rst = 1'b1;
    #2;
    chk("rst_cycle_mreq", 32'(MREQ), 32'h1);
    step();
    rst = 1'b0;
    #2;
    chk("rst_after_mreq", 32'(MREQ), 32'h0);
    chk("rst_after_grant", 32'(grant_o), 32'h0);
    chk("rst_after_mwrb", 32'(MWRB), 32'h0);
    chk("rst_after_mbstrobe", 32'(MBSTROBE), 32'h0);
    chk("rst_after_dstall", 32'(DSTALL), 32'h1);
    step();
    serve(1'b1, 2'b01, BL);
    DREQ = 1'b0; DWRB = 1'b0;
    step();

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
